// File: rtl/pcpi_matrix_pkg.sv
// Shared definitions for the PCPI matrix issuer.
// Holds the custom-0 opcode, the funct3 codes for load/start/clear,
// the operand index map (A, B, bias, threshold), the issuer state
// enum and a helper that packs a PCPI instruction word.
package pcpi_matrix_pkg;

    localparam logic [6:0] OPCODE   = 7'b0001011;

    localparam logic [2:0] F3_LOAD  = 3'b000;
    localparam logic [2:0] F3_CLEAR = 3'b101;
    localparam logic [2:0] F3_START = 3'b111;

    // Operand index map: 9 A, 9 B, 9 bias, then the single threshold.
    localparam logic [4:0] A_BASE    = 5'd0;
    localparam logic [4:0] B_BASE    = 5'd9;
    localparam logic [4:0] BIAS_BASE = 5'd18;
    localparam logic [4:0] THR_ADDR  = 5'd27;
    localparam int         NUM_OPS   = 28;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_CLR,
        ST_DONE
    } state_e;

    // insn = {0, value, funct3, addr, opcode}
    function automatic logic [31:0] make_insn(
        input logic [15:0] value,
        input logic [2:0]  funct3,
        input logic [4:0]  addr,
        input logic [6:0]  opcode
    );
        return {1'b0, value, funct3, addr, opcode};
    endfunction

endpackage

// File: rtl/lsb_pick28.sv
// Lowest-set-bit priority encoder over a 28-bit mask.
// Ports:
//   mask_i  - candidate mask (bit 0 has highest priority)
//   idx_o   - index of the lowest set bit (0 when the mask is empty)
//   any_o   - high when at least one bit of the mask is set
module lsb_pick28 (
    input  logic [27:0] mask_i,
    output logic [4:0]  idx_o,
    output logic        any_o
);

    // Scan from the top down so the lowest set bit is the last to win.
    always_comb begin
        idx_o = '0;
        for (int i = 27; i >= 0; i--) begin
            if (mask_i[i]) begin
                idx_o = 5'(i);
            end
        end
    end

    assign any_o = |mask_i;

endmodule

// File: rtl/pcpi_matrix_issuer.sv
// Stand-alone PCPI initiator for the fused-matrix coprocessor.
// Buffers 28 operands written from a local host port, then on go issues
// one load per dirty operand (ascending index), a start (capturing
// pcpi_rd into result) and a clear, and finally pulses done.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   wr_en, wr_addr, wr_data       - operand write port (ignored while busy)
//   go                            - start a transaction (sampled in IDLE only)
//   busy, done, err, result       - status, completion pulse, sticky timeout, result word
//   pcpi_valid, pcpi_insn         - instruction issue (registered)
//   pcpi_wr, pcpi_rd, pcpi_wait,
//   pcpi_ready                    - coprocessor response
module pcpi_matrix_issuer #(
    parameter logic [6:0] OPCODE  = pcpi_matrix_pkg::OPCODE,
    parameter int         TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic        go,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] result,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    input  logic        pcpi_wait,
    input  logic        pcpi_ready
);
    import pcpi_matrix_pkg::*;

    localparam int          CNT_W      = $clog2(TIMEOUT + 1);
    localparam logic [31:0] START_INSN = make_insn(16'd0, F3_START, 5'd0, OPCODE);
    localparam logic [31:0] CLEAR_INSN = make_insn(16'd0, F3_CLEAR, 5'd0, OPCODE);

    state_e             state_q;
    logic [15:0]        ops_q [NUM_OPS];
    logic [NUM_OPS-1:0] dirty_q;
    logic [4:0]         cur_idx_q;
    logic [CNT_W-1:0]   beat_cnt_q;
    logic               valid_q;
    logic [31:0]        insn_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic [31:0]        result_q;

    logic               wr_ok;
    logic [NUM_OPS-1:0] wr_bit;
    logic [NUM_OPS-1:0] pick_mask;
    logic [4:0]         pick_idx;
    logic               pick_any;
    logic [15:0]        pick_val;
    logic [31:0]        load_insn;
    logic               beat_accept;
    logic               beat_expired;

    // pcpi_wr and pcpi_wait carry no control meaning for the issuer.
    logic               unused_inputs;
    assign unused_inputs = pcpi_wr ^ pcpi_wait;

    // In IDLE the pick must see a write landing in the same cycle as go;
    // in LOAD it must skip the operand whose load is currently on the bus.
    always_comb begin
        wr_ok  = wr_en && (state_q == ST_IDLE) && (wr_addr <= THR_ADDR);
        wr_bit = '0;
        if (wr_ok) begin
            wr_bit[wr_addr] = 1'b1;
        end
        pick_mask = dirty_q & ~(NUM_OPS'(1) << cur_idx_q);
        if (state_q == ST_IDLE) begin
            pick_mask = dirty_q | wr_bit;
        end
    end

    lsb_pick28 u_pick (
        .mask_i (pick_mask),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    // Forward the same-cycle write value so the first load carries it.
    always_comb begin
        pick_val = ops_q[pick_idx];
        if (wr_ok && (wr_addr == pick_idx)) begin
            pick_val = wr_data;
        end
        load_insn = make_insn(pick_val, F3_LOAD, pick_idx, OPCODE);
    end

    // Beat cycle 1 sees a stale ready from the previous instruction.
    assign beat_accept  = (beat_cnt_q >= CNT_W'(2)) && pcpi_ready;
    assign beat_expired = (beat_cnt_q == CNT_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            dirty_q    <= '1;
            cur_idx_q  <= '0;
            beat_cnt_q <= '0;
            valid_q    <= 1'b0;
            insn_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            result_q   <= '0;
            for (int i = 0; i < NUM_OPS; i++) begin
                ops_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            if (wr_ok) begin
                ops_q[wr_addr]   <= wr_data;
                dirty_q[wr_addr] <= 1'b1;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        err_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        valid_q    <= 1'b1;
                        beat_cnt_q <= CNT_W'(1);
                        if (pick_any) begin
                            state_q   <= ST_LOAD;
                            insn_q    <= load_insn;
                            cur_idx_q <= pick_idx;
                        end else begin
                            state_q <= ST_RUN;
                            insn_q  <= START_INSN;
                        end
                    end
                end
                ST_LOAD, ST_RUN, ST_CLR: begin
                    if (beat_accept) begin
                        beat_cnt_q <= CNT_W'(1);
                        case (state_q)
                            ST_LOAD: begin
                                dirty_q[cur_idx_q] <= 1'b0;
                                if (pick_any) begin
                                    insn_q    <= load_insn;
                                    cur_idx_q <= pick_idx;
                                end else begin
                                    state_q <= ST_RUN;
                                    insn_q  <= START_INSN;
                                end
                            end
                            ST_RUN: begin
                                result_q <= pcpi_rd;
                                state_q  <= ST_CLR;
                                insn_q   <= CLEAR_INSN;
                            end
                            default: begin
                                valid_q <= 1'b0;
                                insn_q  <= '0;
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end
                        endcase
                    end else if (beat_expired) begin
                        // Abandon the transaction; unsent operands stay dirty.
                        valid_q <= 1'b0;
                        insn_q  <= '0;
                        err_q   <= 1'b1;
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign result     = result_q;
    assign pcpi_valid = valid_q;
    assign pcpi_insn  = insn_q;

endmodule
